// File: rtl/alu_sequencer.sv
// Program sequencer for the accumulator ALU: replays a stored {opcode, operand}
// program one word per clock, then captures the final accumulator and flags.
module alu_sequencer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WIDTH+2:0]  prog_data,
  input  logic              start,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  output logic [WIDTH-1:0]  alu_in,
  output logic [2:0]        alu_control,
  input  logic [WIDTH-1:0]  alu_accumulator,
  input  logic [3:0]        alu_flags,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic [3:0]        result_flags,
  output logic [ADDR_W:0]   step_count
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state, state_nxt;
  logic [WIDTH+2:0]    mem [DEPTH];
  logic [ADDR_W:0]     pc;
  logic [ADDR_W:0]     run_len;
  logic [ADDR_W:0]     start_len;
  logic                issue;
  logic [ADDR_W-1:0]   issue_addr;
  logic                capture;
  logic                prog_wr;
  logic                launch;

  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
    return (l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  assign start_len = clamp_len(length);
  assign launch    = (state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (start_len != '0) ? RUN : DRAIN;
      RUN: begin
        if (abort)               state_nxt = IDLE;
        else if (pc == run_len)  state_nxt = DRAIN;
      end
      DRAIN:   state_nxt = abort ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // pc always points at the next word to issue; in IDLE a launch issues word 0
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    issue      = 1'b0;
    issue_addr = '0;
    capture    = 1'b0;
    prog_wr    = 1'b0;
    case (state)
      IDLE: begin
        prog_wr = prog_we;
        issue   = start && (start_len != '0);
      end
      RUN: begin
        busy = 1'b1;
        if (!abort && (pc != run_len)) begin
          issue      = 1'b1;
          issue_addr = pc[ADDR_W-1:0];
        end
      end
      DRAIN: begin
        busy    = 1'b1;
        capture = !abort;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Issue stage: registered word presented to the ALU, HOLD/0 when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control  <= '0;
      alu_in       <= '0;
      pc           <= '0;
      step_count   <= '0;
      run_len      <= '0;
      result       <= '0;
      result_flags <= '0;
    end else begin
      {alu_control, alu_in} <= issue ? mem[issue_addr] : '0;
      if (launch) begin
        run_len    <= start_len;
        pc         <= (start_len != '0) ? ONE : '0;
        step_count <= (start_len != '0) ? ONE : '0;
      end else if (issue) begin
        pc         <= pc + ONE;
        step_count <= step_count + ONE;
      end
      if (capture) begin
        result       <= alu_accumulator;
        result_flags <= alu_flags;
      end
    end
  end

  // Program store is not reset; mem[0] read by a launch sees the pre-write value
  always_ff @(posedge clk) begin
    if (prog_wr) mem[prog_addr] <= prog_data;
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural accumulator ALU closes the loop and a
// scoreboard of issued words and final results is checked per scenario.
module tb_alu_sequencer;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  localparam logic [2:0] HOLD = 3'd0, CLEAR = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] AND_OP = 3'd4, NEG = 3'd5, NOT_OP = 3'd6, XOR_OP = 3'd7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              prog_we = 1'b0;
  logic [ADDR_W-1:0] prog_addr = '0;
  logic [WIDTH+2:0]  prog_data = '0;
  logic              start = 1'b0;
  logic [ADDR_W:0]   length = '0;
  logic              abort = 1'b0;
  logic [WIDTH-1:0]  alu_in;
  logic [2:0]        alu_control;
  logic [WIDTH-1:0]  alu_accumulator;
  logic [3:0]        alu_flags;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic [3:0]        result_flags;
  logic [ADDR_W:0]   step_count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [WIDTH+2:0] shadow [DEPTH];
  logic [WIDTH+2:0] word_q [$];
  logic [WIDTH+3:0] res_q  [$];
  logic [WIDTH-1:0] acc;

  always #5 clk = ~clk;

  alu_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .length(length), .abort(abort),
    .alu_in(alu_in), .alu_control(alu_control), .alu_accumulator(alu_accumulator),
    .alu_flags(alu_flags), .busy(busy), .done(done), .result(result),
    .result_flags(result_flags), .step_count(step_count)
  );

  function automatic logic [WIDTH-1:0] alu_op(input logic [WIDTH-1:0] a,
                                              input logic [2:0] op,
                                              input logic [WIDTH-1:0] b);
    case (op)
      CLEAR:   return '0;
      ADD:     return a + b;
      SUB:     return a - b;
      AND_OP:  return a & b;
      NEG:     return -a;
      NOT_OP:  return ~a;
      XOR_OP:  return a ^ b;
      default: return a;
    endcase
  endfunction

  function automatic logic [3:0] flags_of(input logic [WIDTH-1:0] a);
    return {a == '0, a[WIDTH-1], ^a, a[0]};
  endfunction

  // Behavioural accumulator ALU on the other side of the interface
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc <= '0;
    else        acc <= alu_op(acc, alu_control, alu_in);
  end
  assign alu_accumulator = acc;
  assign alu_flags       = flags_of(acc);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_word(input int addr, input logic [2:0] op, input logic [WIDTH-1:0] opnd);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = addr[ADDR_W-1:0];
    prog_data = {op, opnd};
    @(negedge clk);
    prog_we = 1'b0;
    shadow[addr] = {op, opnd};
  endtask

  // Launch a run and check every issued word, busy, latency, result and step count
  task automatic run_prog(input string tag, input int len_in, input bit wr,
                          input int wa, input logic [WIDTH+2:0] wd);
    int l;
    int edges;
    bit seen;
    logic [WIDTH-1:0] a;
    logic [WIDTH+2:0] w;
    logic [WIDTH+3:0] r;
    l = (len_in > DEPTH) ? DEPTH : len_in;
    word_q.delete();
    res_q.delete();
    @(negedge clk);
    a = acc;
    for (int i = 0; i < l; i++) begin
      word_q.push_back(shadow[i]);
      a = alu_op(a, shadow[i][WIDTH+2:WIDTH], shadow[i][WIDTH-1:0]);
    end
    word_q.push_back('0);
    res_q.push_back({flags_of(a), a});
    start  = 1'b1;
    length = len_in[ADDR_W:0];
    if (wr) begin
      prog_we   = 1'b1;
      prog_addr = wa[ADDR_W-1:0];
      prog_data = wd;
    end
    @(posedge clk); #1;
    start   = 1'b0;
    prog_we = 1'b0;
    if (wr) shadow[wa] = wd;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      if (word_q.size() > 0) begin
        w = word_q.pop_front();
        n_cmp++;
        if ({alu_control, alu_in} !== w) begin
          n_bad++;
          $display("FAIL %s issue@%0d: got %h want %h", tag, edges, {alu_control, alu_in}, w);
        end
      end
      n_cmp++;
      if (busy !== (edges <= l)) begin
        n_bad++;
        $display("FAIL %s busy@%0d: got %b want %b", tag, edges, busy, (edges <= l));
      end
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        edges++;
      end
    end
    n_cmp++;
    if (!seen) begin
      n_bad++;
      $display("FAIL %s done_timeout: got no done want done after %0d edges", tag, l + 1);
    end else begin
      r = res_q.pop_front();
      n_cmp++;
      if (edges !== l + 1) begin
        n_bad++;
        $display("FAIL %s latency: got %0d want %0d", tag, edges, l + 1);
      end
      n_cmp++;
      if (result !== r[WIDTH-1:0]) begin
        n_bad++;
        $display("FAIL %s result: got %h want %h", tag, result, r[WIDTH-1:0]);
      end
      n_cmp++;
      if (result_flags !== r[WIDTH+3:WIDTH]) begin
        n_bad++;
        $display("FAIL %s flags: got %h want %h", tag, result_flags, r[WIDTH+3:WIDTH]);
      end
      n_cmp++;
      if (step_count !== (ADDR_W+1)'(l)) begin
        n_bad++;
        $display("FAIL %s step_count: got %0d want %0d", tag, step_count, l);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0) begin
        n_bad++;
        $display("FAIL %s done_width: got %b want 0", tag, done);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({alu_control, alu_in, busy, done, result, result_flags, step_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got %h want 0",
               {alu_control, alu_in, busy, done, result, result_flags, step_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    write_word(0, CLEAR, 8'h00);
    write_word(1, ADD,   8'h05);
    write_word(2, SUB,   8'h03);
    run_prog("basic", 3, 1'b0, 0, '0);
    n_cmp++;
    if (result !== 8'h02) begin
      n_bad++;
      $display("FAIL basic_value: got %h want 02", result);
    end
  endtask

  task automatic test_mask;
    write_word(0, CLEAR,  8'h00);
    write_word(1, ADD,    8'h0C);
    write_word(2, AND_OP, 8'h0A);
    write_word(3, XOR_OP, 8'h09);
    run_prog("mask", 4, 1'b0, 0, '0);
    n_cmp++;
    if (result !== 8'h01) begin
      n_bad++;
      $display("FAIL mask_value: got %h want 01", result);
    end
  endtask

  task automatic test_len0;
    run_prog("len0", 0, 1'b0, 0, '0);
    n_cmp++;
    if (result !== 8'h01) begin
      n_bad++;
      $display("FAIL len0_value: got %h want 01", result);
    end
  endtask

  task automatic test_clamp;
    for (int i = 0; i < DEPTH; i++) begin
      case (i % 4)
        0:       write_word(i, ADD,    8'(i * 7 + 3));
        1:       write_word(i, XOR_OP, 8'(i * 13 + 1));
        2:       write_word(i, SUB,    8'(i + 2));
        default: write_word(i, (i == 3) ? NEG : NOT_OP, 8'h00);
      endcase
    end
    run_prog("clamp", 20, 1'b0, 0, '0);
  endtask

  task automatic test_abort;
    logic [WIDTH-1:0] old_res;
    logic [3:0] old_fl;
    bit got_done;
    write_word(0, ADD, 8'h01);
    write_word(1, ADD, 8'h02);
    write_word(2, ADD, 8'h04);
    write_word(3, ADD, 8'h08);
    old_res = result;
    old_fl  = result_flags;
    @(negedge clk);
    start  = 1'b1;
    length = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    abort     = 1'b1;
    start     = 1'b1;
    length    = 5'd2;
    prog_we   = 1'b1;
    prog_addr = '0;
    prog_data = {XOR_OP, 8'hFF};
    @(posedge clk); #1;
    abort   = 1'b0;
    start   = 1'b0;
    prog_we = 1'b0;
    n_cmp++;
    if ({busy, alu_control, alu_in} !== '0) begin
      n_bad++;
      $display("FAIL abort_idle: got %h want 0", {busy, alu_control, alu_in});
    end
    got_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) got_done = 1'b1;
    end
    n_cmp++;
    if (got_done) begin
      n_bad++;
      $display("FAIL abort_no_done: got done=1 want 0");
    end
    n_cmp++;
    if ({result_flags, result} !== {old_fl, old_res}) begin
      n_bad++;
      $display("FAIL abort_hold: got %h want %h", {result_flags, result}, {old_fl, old_res});
    end
    run_prog("readback", 4, 1'b0, 0, '0);
  endtask

  task automatic test_start_with_write;
    run_prog("start_wr", 3, 1'b1, 0, {XOR_OP, 8'h55});
    run_prog("start_wr_after", 1, 1'b0, 0, '0);
  endtask

  task automatic test_reset_mid_run;
    write_word(0, ADD, 8'h11);
    write_word(1, ADD, 8'h22);
    write_word(2, ADD, 8'h33);
    @(negedge clk);
    start  = 1'b1;
    length = 5'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({alu_control, alu_in, busy, done, result, result_flags, step_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_run: got %h want 0",
               {alu_control, alu_in, busy, done, result, result_flags, step_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_len0();
    test_clamp();
    test_abort();
    test_start_with_write();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
